id_ex_reg: RTL and testbench
============================

// Module: id_ex_reg
// PURPOSE
// - ID->EX pipeline register of the 5-stage RV64 core: captures the decoded-instruction bundle
//   from the IDU each cycle and presents it, one cycle later, to the EXU and the EX->MEM register.
// - Supports stall (hold) and bubble insertion. It is purely a register bank with no datapath logic.
// PARAMETERS
// - none. All widths are fixed by the core: XLEN=64, inst=32, alu_op=17, regaddr=5.
// PORTS (name  dir  width  meaning)
// - clk             in   1   single clock, all state updates on posedge
// - rst             in   1   asynchronous, active-high reset
// - valid           in   1   1 = id_* bundle is a real instruction; 0 = load a bubble
// - ena             in   1   1 = register updates at posedge; 0 = hold (stall)
// - id_pc/ex_pc                 in/out  64  instruction PC
// - id_inst/ex_inst             in/out  32  raw instruction word
// - id_alu_op/ex_alu_op         in/out  17  one-hot ALU operation
// - id_sel_rfres/ex_sel_rfres   in/out   2  regfile write-data source select
// - id_mem_wen/ex_mem_wen       in/out   1  data-memory write enable
// - id_mem_ena/ex_mem_ena       in/out   1  data-memory access enable
// - id_mem_mask/ex_mem_mask     in/out   4  memory byte-size mask
// - id_sel_alures/ex_sel_alures in/out   4  ALU result post-processing select
// - id_alu_src1/ex_alu_src1     in/out  64  ALU operand 1
// - id_alu_src2/ex_alu_src2     in/out  64  ALU operand 2
// - id_rf_rdata2/ex_rf_rdata2   in/out  64  rs2 value (store data)
// - id_sel_memdata/ex_sel_memdata in/out 2  load-data extension select
// - id_rf_we/ex_rf_we           in/out   1  regfile write enable
// - id_rf_waddr/ex_rf_waddr     in/out   5  regfile write address
// - id_sys/ex_sys               in/out   1  ebreak/system flag (ends simulation at WB)
// BEHAVIOUR
// - Every ex_* output is driven directly by a flop. There is no combinational path from id_* to ex_*.
// - Reset: while rst=1, all ex_* outputs are forced immediately (asynchronously) to the bubble value.
// - Bubble value:
//   - all fields are 0, except ex_inst = 32'h0000_0013 (NOP).
//   - consequently ex_rf_we=0, ex_mem_ena=0, ex_mem_wen=0 and ex_sys=0.
// - Posedge, rst=0, priority order:
//   1. ena=0: all outputs hold their value. valid is ignored.
//   2. ena=1, valid=1: every ex_X takes id_X. Latency is exactly 1 cycle.
//   3. ena=1, valid=0: all outputs take the bubble value.
// - rst asserted mid-stream: outputs clear at once, without waiting for a clock edge.
//   After rst deasserts, the first posedge with ena=1 loads normally.
// - rst has priority over ena and valid.
// - Fields are copied bit-exact: no sign extension, truncation or decoding.
// - X on id_* while valid=0 or ena=0 must not propagate to any output.
// - In the current top-level, valid is tied to 1 and ena is ~rst. The stall and bubble paths
//   are still mandatory.
// TESTING
// - Reset: drive rst=1 between clock edges.
//   -> all outputs clear immediately: ex_pc=0, ex_inst=0x00000013, ex_rf_we=0, ex_sys=0.
// - Pass-through: rst=0, ena=1, valid=1, id_pc=0x80000000, id_inst=0x00100093,
//   id_alu_src1=0xFFFF_FFFF_FFFF_FFFF, id_rf_waddr=1, id_rf_we=1.
//   -> after 1 posedge, ex_* match these values bit-exact.
// - Stall: load pc=0x80000004, then set ena=0 and change all id_* for 3 cycles.
//   -> ex_pc stays 0x80000004 and all other outputs are unchanged.
// - Bubble: ena=1, valid=0, with id_rf_we=1, id_mem_wen=1, id_sys=1.
//   -> next posedge: ex_rf_we=0, ex_mem_wen=0, ex_sys=0, ex_inst=0x00000013.
// - Async reset mid-run: pulse rst between edges while holding a non-zero bundle.
//   -> outputs clear before the next posedge; the first post-reset edge with ena=1 loads id_*.
// - Width corners: alu_op=17'h10000, mem_mask=4'hF, rf_waddr=5'd31, rf_rdata2=64'h8000_0000_0000_0001.
//   -> all pass through unchanged.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register of the 5-stage RV64 core.
// Holds on stall, loads a NOP bubble on invalid input, clears asynchronously on reset.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ena,
    input  logic [63:0] id_pc,
    input  logic [31:0] id_inst,
    input  logic [16:0] id_alu_op,
    input  logic [1:0]  id_sel_rfres,
    input  logic        id_mem_wen,
    input  logic        id_mem_ena,
    input  logic [3:0]  id_mem_mask,
    input  logic [3:0]  id_sel_alures,
    input  logic [63:0] id_alu_src1,
    input  logic [63:0] id_alu_src2,
    input  logic [63:0] id_rf_rdata2,
    input  logic [1:0]  id_sel_memdata,
    input  logic        id_rf_we,
    input  logic [4:0]  id_rf_waddr,
    input  logic        id_sys,
    output logic [63:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [16:0] ex_alu_op,
    output logic [1:0]  ex_sel_rfres,
    output logic        ex_mem_wen,
    output logic        ex_mem_ena,
    output logic [3:0]  ex_mem_mask,
    output logic [3:0]  ex_sel_alures,
    output logic [63:0] ex_alu_src1,
    output logic [63:0] ex_alu_src2,
    output logic [63:0] ex_rf_rdata2,
    output logic [1:0]  ex_sel_memdata,
    output logic        ex_rf_we,
    output logic [4:0]  ex_rf_waddr,
    output logic        ex_sys
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [16:0] alu_op;
        logic [1:0]  sel_rfres;
        logic        mem_wen;
        logic        mem_ena;
        logic [3:0]  mem_mask;
        logic [3:0]  sel_alures;
        logic [63:0] alu_src1;
        logic [63:0] alu_src2;
        logic [63:0] rf_rdata2;
        logic [1:0]  sel_memdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sys;
    } bundle_t;

    // Bubble is built from constants only, so X on id_* never reaches it.
    localparam bundle_t BUBBLE = '{
        pc:          64'd0,
        inst:        NOP,
        alu_op:      17'd0,
        sel_rfres:   2'd0,
        mem_wen:     1'b0,
        mem_ena:     1'b0,
        mem_mask:    4'd0,
        sel_alures:  4'd0,
        alu_src1:    64'd0,
        alu_src2:    64'd0,
        rf_rdata2:   64'd0,
        sel_memdata: 2'd0,
        rf_we:       1'b0,
        rf_waddr:    5'd0,
        sys:         1'b0
    };

    bundle_t d;
    bundle_t q;

    // Gather the incoming decode bundle.
    always_comb begin
        d             = BUBBLE;
        d.pc          = id_pc;
        d.inst        = id_inst;
        d.alu_op      = id_alu_op;
        d.sel_rfres   = id_sel_rfres;
        d.mem_wen     = id_mem_wen;
        d.mem_ena     = id_mem_ena;
        d.mem_mask    = id_mem_mask;
        d.sel_alures  = id_sel_alures;
        d.alu_src1    = id_alu_src1;
        d.alu_src2    = id_alu_src2;
        d.rf_rdata2   = id_rf_rdata2;
        d.sel_memdata = id_sel_memdata;
        d.rf_we       = id_rf_we;
        d.rf_waddr    = id_rf_waddr;
        d.sys         = id_sys;
    end

    // Pipeline register: reset > stall hold > load or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (ena) begin
            if (valid) begin
                q <= d;
            end else begin
                q <= BUBBLE;
            end
        end
    end

    assign ex_pc          = q.pc;
    assign ex_inst        = q.inst;
    assign ex_alu_op      = q.alu_op;
    assign ex_sel_rfres   = q.sel_rfres;
    assign ex_mem_wen     = q.mem_wen;
    assign ex_mem_ena     = q.mem_ena;
    assign ex_mem_mask    = q.mem_mask;
    assign ex_sel_alures  = q.sel_alures;
    assign ex_alu_src1    = q.alu_src1;
    assign ex_alu_src2    = q.alu_src2;
    assign ex_rf_rdata2   = q.rf_rdata2;
    assign ex_sel_memdata = q.sel_memdata;
    assign ex_rf_we       = q.rf_we;
    assign ex_rf_waddr    = q.rf_waddr;
    assign ex_sys         = q.sys;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: table-driven vectors plus
// hand-written reset / stall sequences.
module tb_id_ex_reg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [16:0] alu_op;
        logic [1:0]  sel_rfres;
        logic        mem_wen;
        logic        mem_ena;
        logic [3:0]  mem_mask;
        logic [3:0]  sel_alures;
        logic [63:0] alu_src1;
        logic [63:0] alu_src2;
        logic [63:0] rf_rdata2;
        logic [1:0]  sel_memdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sys;
    } bundle_t;

    typedef struct {
        string   name;
        logic    ena;
        logic    valid;
        bundle_t din;
        bundle_t exp;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    valid;
    logic    ena;
    bundle_t din;
    bundle_t dout;

    logic [63:0] ex_pc;
    logic [31:0] ex_inst;
    logic [16:0] ex_alu_op;
    logic [1:0]  ex_sel_rfres;
    logic        ex_mem_wen;
    logic        ex_mem_ena;
    logic [3:0]  ex_mem_mask;
    logic [3:0]  ex_sel_alures;
    logic [63:0] ex_alu_src1;
    logic [63:0] ex_alu_src2;
    logic [63:0] ex_rf_rdata2;
    logic [1:0]  ex_sel_memdata;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic        ex_sys;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .ena            (ena),
        .id_pc          (din.pc),
        .id_inst        (din.inst),
        .id_alu_op      (din.alu_op),
        .id_sel_rfres   (din.sel_rfres),
        .id_mem_wen     (din.mem_wen),
        .id_mem_ena     (din.mem_ena),
        .id_mem_mask    (din.mem_mask),
        .id_sel_alures  (din.sel_alures),
        .id_alu_src1    (din.alu_src1),
        .id_alu_src2    (din.alu_src2),
        .id_rf_rdata2   (din.rf_rdata2),
        .id_sel_memdata (din.sel_memdata),
        .id_rf_we       (din.rf_we),
        .id_rf_waddr    (din.rf_waddr),
        .id_sys         (din.sys),
        .ex_pc          (ex_pc),
        .ex_inst        (ex_inst),
        .ex_alu_op      (ex_alu_op),
        .ex_sel_rfres   (ex_sel_rfres),
        .ex_mem_wen     (ex_mem_wen),
        .ex_mem_ena     (ex_mem_ena),
        .ex_mem_mask    (ex_mem_mask),
        .ex_sel_alures  (ex_sel_alures),
        .ex_alu_src1    (ex_alu_src1),
        .ex_alu_src2    (ex_alu_src2),
        .ex_rf_rdata2   (ex_rf_rdata2),
        .ex_sel_memdata (ex_sel_memdata),
        .ex_rf_we       (ex_rf_we),
        .ex_rf_waddr    (ex_rf_waddr),
        .ex_sys         (ex_sys)
    );

    always_comb begin
        dout             = '0;
        dout.pc          = ex_pc;
        dout.inst        = ex_inst;
        dout.alu_op      = ex_alu_op;
        dout.sel_rfres   = ex_sel_rfres;
        dout.mem_wen     = ex_mem_wen;
        dout.mem_ena     = ex_mem_ena;
        dout.mem_mask    = ex_mem_mask;
        dout.sel_alures  = ex_sel_alures;
        dout.alu_src1    = ex_alu_src1;
        dout.alu_src2    = ex_alu_src2;
        dout.rf_rdata2   = ex_rf_rdata2;
        dout.sel_memdata = ex_sel_memdata;
        dout.rf_we       = ex_rf_we;
        dout.rf_waddr    = ex_rf_waddr;
        dout.sys         = ex_sys;
    end

    task automatic chk(input string name, input bundle_t exp);
        total++;
        if (dout !== exp)
            $display("FAIL %s: got %h expected %h", name, dout, exp);
        else
            passed++;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %b expected %b", name, got, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bundle_t BUB, A, B, C, D, P, XB, Q;
    vec_t    vecs[9];

    initial begin
        BUB      = '0;
        BUB.inst = 32'h0000_0013;

        A          = '0;
        A.pc       = 64'h0000_0000_8000_0000;
        A.inst     = 32'h0010_0093;
        A.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        A.rf_waddr = 5'd1;
        A.rf_we    = 1'b1;
        A.alu_op   = 17'h00001;

        B           = '0;
        B.pc        = 64'h0000_0000_8000_0010;
        B.inst      = 32'h0020_B023;
        B.alu_op    = 17'h10000;
        B.mem_mask  = 4'hF;
        B.rf_waddr  = 5'd31;
        B.rf_rdata2 = 64'h8000_0000_0000_0001;
        B.mem_ena   = 1'b1;
        B.mem_wen   = 1'b1;

        C             = '0;
        C.pc          = 64'h1234_5678_9ABC_DEF0;
        C.inst        = 32'h0010_0073;
        C.rf_we       = 1'b1;
        C.mem_wen     = 1'b1;
        C.mem_ena     = 1'b1;
        C.sys         = 1'b1;
        C.sel_rfres   = 2'b10;
        C.sel_alures  = 4'b0101;
        C.sel_memdata = 2'b01;
        C.alu_src2    = 64'hDEAD_BEEF_0000_0001;
        C.rf_waddr    = 5'd10;

        D = '1;
        XB = 'x;

        vecs[0] = '{"pass_through", 1'b1, 1'b1, A, A};
        vecs[1] = '{"width_corners", 1'b1, 1'b1, B, B};
        vecs[2] = '{"bubble", 1'b1, 1'b0, C, BUB};
        vecs[3] = '{"all_ones", 1'b1, 1'b1, D, D};
        vecs[4] = '{"stall_valid", 1'b0, 1'b1, A, D};
        vecs[5] = '{"stall_invalid", 1'b0, 1'b0, B, D};
        vecs[6] = '{"bubble_x_in", 1'b1, 1'b0, XB, BUB};
        vecs[7] = '{"load_sys", 1'b1, 1'b1, C, C};
        vecs[8] = '{"stall_x_in", 1'b0, 1'b0, XB, C};

        // Async reset at time zero, checked before any edge
        rst   = 1'b1;
        ena   = 1'b1;
        valid = 1'b1;
        din   = C;
        #2;
        chk("reset_state", BUB);
        chk_bit("reset_rf_we", ex_rf_we, 1'b0);

        // Reset has priority over ena/valid at an edge
        step();
        chk("reset_over_edge", BUB);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            ena   = vecs[i].ena;
            valid = vecs[i].valid;
            din   = vecs[i].din;
            step();
            chk(vecs[i].name, vecs[i].exp);
        end

        // Stall: load P, then hold for 3 cycles while id_* churns
        P    = A;
        P.pc = 64'h0000_0000_8000_0004;
        ena   = 1'b1;
        valid = 1'b1;
        din   = P;
        step();
        chk("stall_load", P);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Q      = C;
            Q.pc   = 64'h100 + 64'(i);
            Q.sys  = i[0];
            din    = Q;
            valid  = i[1];
            step();
            chk($sformatf("stall_hold%0d", i), P);
        end

        // Mid-run async reset pulse between edges
        ena   = 1'b1;
        valid = 1'b1;
        din   = C;
        step();
        chk("pre_reset_load", C);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clear", BUB);
        chk_bit("async_clear_sys", ex_sys, 1'b0);
        #1;
        rst = 1'b0;
        din = B;
        step();
        chk("post_reset_load", B);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
